// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word load-store sequencer for a single-port
// word-wide memory with combinational reads and clocked writes.
//   clk, rst        : clock, synchronous active-high reset
//   req_*           : core request (valid/ready, we, funct3, addr, wdata)
//   rsp_*           : one-cycle completion pulse with extended load data / error
//   mem_*           : word-aligned memory port (EnWR, ABus, DBusW, DBusR)
// Sub-word stores read the word first (READ), then write the merged word
// (WRITE). Full-word stores skip the read.
module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_EnWR,
  output logic [31:0] mem_ABus,
  output logic [31:0] mem_DBusW,
  input  logic [31:0] mem_DBusR
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  logic [1:0]  state, state_nxt;
  req_t        cur;
  logic [31:0] wbuf;

  logic        accept;
  logic        acc_err, acc_illegal, acc_misal;
  logic [32:0] acc_size, acc_end;

  // Request classification on the incoming fields; 33-bit end address so an
  // access near 2^32 cannot wrap into range.
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   acc_size = 33'd1;
      2'b01:   acc_size = 33'd2;
      default: acc_size = 33'd4;
    endcase
    acc_end = {1'b0, req_addr} + acc_size;
    if (req_we) acc_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else        acc_illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
    acc_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    acc_err   = acc_illegal || acc_misal || (acc_end > 33'(MEM_BYTES));
  end

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) begin
               if (acc_err)                              state_nxt = RESP;
               else if (req_we && req_funct3 == 3'b010)  state_nxt = WRITE;
               else                                      state_nxt = READ;
             end
      READ:  state_nxt = cur.we ? WRITE : RESP;
      WRITE: state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      wbuf  <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cur <= '{we: req_we, funct3: req_funct3, addr: req_addr,
                 wdata: req_wdata, err: acc_err};
      if (state == READ) wbuf <= mem_DBusR;
    end
  end

  // Memory port: address only while touching memory; write enable gated by
  // rst so a reset landing on a WRITE cycle suppresses the store.
  always_comb begin
    mem_ABus  = '0;
    mem_DBusW = '0;
    if (state == READ || state == WRITE) mem_ABus = {cur.addr[31:2], 2'b00};
    if (state == WRITE) begin
      case (cur.funct3[1:0])
        2'b00: begin
          mem_DBusW = wbuf;
          mem_DBusW[{cur.addr[1:0], 3'b000} +: 8] = cur.wdata[7:0];
        end
        2'b01: begin
          mem_DBusW = wbuf;
          mem_DBusW[{cur.addr[1], 4'b0000} +: 16] = cur.wdata[15:0];
        end
        default: mem_DBusW = cur.wdata;
      endcase
    end
  end

  assign mem_EnWR = (state == WRITE) && !rst;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = wbuf[{cur.addr[1:0], 3'b000} +: 8];
  assign lane_h = cur.addr[1] ? wbuf[31:16] : wbuf[15:0];

  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && cur.err;

  always_comb begin
    rsp_rdata = '0;
    if (state == RESP && !cur.err && !cur.we) begin
      case (cur.funct3)
        3'b000:  rsp_rdata = {{24{lane_b[7]}}, lane_b};
        3'b100:  rsp_rdata = {24'd0, lane_b};
        3'b001:  rsp_rdata = {{16{lane_h[15]}}, lane_h};
        3'b101:  rsp_rdata = {16'd0, lane_h};
        default: rsp_rdata = wbuf;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_EnWR;
  logic [31:0] mem_ABus, mem_DBusW, mem_DBusR;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_EnWR(mem_EnWR), .mem_ABus(mem_ABus), .mem_DBusW(mem_DBusW),
    .mem_DBusR(mem_DBusR)
  );

  // Memory model: combinational read, clocked write, plus a preload port
  // so all array writes live in one process.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;
  int          wr_cnt = 0, acc_cnt = 0;
  logic [31:0] last_wa, last_wd;

  assign mem_DBusR = mem[mem_ABus[11:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_EnWR) begin
      mem[mem_ABus[11:2]] <= mem_DBusW;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_ABus;
      last_wd <= mem_DBusW;
    end
    if (mem_ABus != 32'd0) acc_cnt <= acc_cnt + 1;
  end

  int n_checks = 0, n_fail = 0;

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  exp_t sb[$];

  task automatic poke(input logic [9:0] idx, input logic [31:0] v);
    @(negedge clk); pl_idx = idx; pl_val = v; pl_en = 1'b1;
    @(negedge clk); pl_en = 1'b0;
  endtask

  // One access: push expectation, drive until accepted, wait (bounded) for
  // the response, pop and compare rdata/err/latency and the pulse width.
  task automatic do_access(input string nm, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee, input int el);
    exp_t e, g;
    int   lat;
    e.rdata = er; e.err = ee; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s ready: got %b want 1", nm, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    g = sb.pop_front();
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s timeout: no rsp_valid within %0d cycles", nm, lat);
    end else begin
      n_checks += 3;
      if (rsp_rdata !== g.rdata) begin n_fail++; $display("FAIL %s rdata: got %h want %h", nm, rsp_rdata, g.rdata); end
      if (rsp_err !== g.err) begin n_fail++; $display("FAIL %s err: got %b want %b", nm, rsp_err, g.err); end
      if (lat != g.lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, lat, g.lat); end
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s pulse: rsp_valid still %b", nm, rsp_valid); end
  endtask

  task automatic test_reset();
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks += 7;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_err !== 1'b0)   begin n_fail++; $display("FAIL reset rsp_err: got %b want 0", rsp_err); end
    if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset rdata: got %h want 0", rsp_rdata); end
    if (mem_EnWR !== 1'b0)  begin n_fail++; $display("FAIL reset EnWR: got %b want 0", mem_EnWR); end
    if (mem_ABus !== 32'd0) begin n_fail++; $display("FAIL reset ABus: got %h want 0", mem_ABus); end
    if (mem_DBusW !== 32'd0) begin n_fail++; $display("FAIL reset DBusW: got %h want 0", mem_DBusW); end
  endtask

  task automatic test_load();
    int w0;
    poke(10'd4, 32'h8899AABB);
    poke(10'd5, 32'h7F016502);
    w0 = wr_cnt;
    do_access("lb_11",  1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
    do_access("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2);
    do_access("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    do_access("lbu_10", 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000BB, 1'b0, 2);
    do_access("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2);
    do_access("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2);
    do_access("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2);
    do_access("lb_14",  1'b0, 3'b000, 32'h14, 32'h0, 32'h00000002, 1'b0, 2);
    do_access("lh_16",  1'b0, 3'b001, 32'h16, 32'h0, 32'h00007F01, 1'b0, 2);
    n_checks++;
    if (wr_cnt != w0) begin n_fail++; $display("FAIL load_writes: got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_store();
    int w0;
    poke(10'd8, 32'h11223344);
    w0 = wr_cnt;
    do_access("sh_22", 1'b1, 3'b001, 32'h22, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    n_checks += 4;
    if (wr_cnt != w0 + 1) begin n_fail++; $display("FAIL sh_22 writes: got %0d want 1", wr_cnt - w0); end
    if (last_wa !== 32'h20) begin n_fail++; $display("FAIL sh_22 waddr: got %h want 00000020", last_wa); end
    if (last_wd !== 32'hBEEF3344) begin n_fail++; $display("FAIL sh_22 wdata: got %h want beef3344", last_wd); end
    if (mem[8] !== 32'hBEEF3344) begin n_fail++; $display("FAIL sh_22 mem: got %h want beef3344", mem[8]); end
    do_access("sb_21", 1'b1, 3'b000, 32'h21, 32'h00000055, 32'h0, 1'b0, 3);
    n_checks++;
    if (mem[8] !== 32'hBEEF5544) begin n_fail++; $display("FAIL sb_21 mem: got %h want beef5544", mem[8]); end
    do_access("sh_20", 1'b1, 3'b001, 32'h20, 32'h00001234, 32'h0, 1'b0, 3);
    n_checks++;
    if (mem[8] !== 32'hBEEF1234) begin n_fail++; $display("FAIL sh_20 mem: got %h want beef1234", mem[8]); end
    w0 = wr_cnt;
    do_access("sw_ffc", 1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    n_checks += 2;
    if (wr_cnt != w0 + 1) begin n_fail++; $display("FAIL sw_ffc writes: got %0d want 1", wr_cnt - w0); end
    if (mem[1023] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_ffc mem: got %h want cafef00d", mem[1023]); end
    do_access("lb_fff", 1'b0, 3'b000, 32'hFFF, 32'h0, 32'hFFFFFFCA, 1'b0, 2);
  endtask

  task automatic test_errors();
    int w0, a0;
    w0 = wr_cnt; a0 = acc_cnt;
    do_access("lw_06",    1'b0, 3'b010, 32'h06,   32'h0, 32'h0, 1'b1, 1);
    n_checks++;
    if (acc_cnt != a0) begin n_fail++; $display("FAIL lw_06 access: got %0d mem cycles want 0", acc_cnt - a0); end
    do_access("sw_1000",  1'b1, 3'b010, 32'h1000, 32'h12345678, 32'h0, 1'b1, 1);
    do_access("lb_1000",  1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
    do_access("lh_fff",   1'b0, 3'b001, 32'hFFF,  32'h0, 32'h0, 1'b1, 1);
    do_access("lw_ffe",   1'b0, 3'b010, 32'hFFE,  32'h0, 32'h0, 1'b1, 1);
    do_access("sh_11",    1'b1, 3'b001, 32'h11,   32'hFFFF, 32'h0, 1'b1, 1);
    do_access("ld_f3_3",  1'b0, 3'b011, 32'h10,   32'h0, 32'h0, 1'b1, 1);
    do_access("ld_f3_6",  1'b0, 3'b110, 32'h10,   32'h0, 32'h0, 1'b1, 1);
    do_access("st_f3_4",  1'b1, 3'b100, 32'h10,   32'h0, 32'h0, 1'b1, 1);
    do_access("st_f3_5",  1'b1, 3'b101, 32'h10,   32'h0, 32'h0, 1'b1, 1);
    n_checks += 3;
    if (wr_cnt != w0) begin n_fail++; $display("FAIL err_writes: got %0d want 0", wr_cnt - w0); end
    if (acc_cnt != a0) begin n_fail++; $display("FAIL err_access: got %0d mem cycles want 0", acc_cnt - a0); end
    if (mem[4] !== 32'h8899AABB) begin n_fail++; $display("FAIL err_mem: got %h want 8899aabb", mem[4]); end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    poke(10'd2, 32'h01020304);
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h09; req_wdata = 32'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks += 2;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rmw_read ready: got %b want 0", req_ready); end
    if (mem_ABus !== 32'h08) begin n_fail++; $display("FAIL rmw_read ABus: got %h want 00000008", mem_ABus); end
    @(negedge clk);
    n_checks++;
    if (mem_EnWR !== 1'b1) begin n_fail++; $display("FAIL rmw_write EnWR: got %b want 1", mem_EnWR); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_EnWR !== 1'b0) begin n_fail++; $display("FAIL rmw_rst EnWR: got %b want 0", mem_EnWR); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks += 9;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmw rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_err !== 1'b0)   begin n_fail++; $display("FAIL rmw rsp_err: got %b want 0", rsp_err); end
    if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rmw rdata: got %h want 0", rsp_rdata); end
    if (mem_EnWR !== 1'b0)  begin n_fail++; $display("FAIL rmw EnWR: got %b want 0", mem_EnWR); end
    if (mem_ABus !== 32'd0) begin n_fail++; $display("FAIL rmw ABus: got %h want 0", mem_ABus); end
    if (mem_DBusW !== 32'd0) begin n_fail++; $display("FAIL rmw DBusW: got %h want 0", mem_DBusW); end
    if (mem[2] !== 32'h01020304) begin n_fail++; $display("FAIL rmw mem: got %h want 01020304", mem[2]); end
    if (wr_cnt != w0) begin n_fail++; $display("FAIL rmw writes: got %0d want 0", wr_cnt - w0); end
    do_access("rmw_lw", 1'b0, 3'b010, 32'h08, 32'h0, 32'h01020304, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rdy_pat, vld_pat;
    exp_t e, g;
    int   nrsp;
    rdy_pat = 8'b11001001;   // bit n = req_ready at negedge n
    vld_pat = 8'b00100100;   // bit n = rsp_valid at negedge n
    nrsp = 0;
    e.rdata = 32'h8899AABB; e.err = 1'b0; e.lat = 2; sb.push_back(e);
    e.rdata = 32'h000000AA; e.err = 1'b0; e.lat = 2; sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 1) begin req_funct3 = 3'b100; req_addr = 32'h11; end
      if (cyc == 4) req_valid = 1'b0;
      n_checks += 2;
      if (req_ready !== rdy_pat[cyc]) begin n_fail++; $display("FAIL b2b ready c%0d: got %b want %b", cyc, req_ready, rdy_pat[cyc]); end
      if (rsp_valid !== vld_pat[cyc]) begin n_fail++; $display("FAIL b2b rsp_valid c%0d: got %b want %b", cyc, rsp_valid, vld_pat[cyc]); end
      if (rsp_valid === 1'b1 && sb.size() > 0) begin
        g = sb.pop_front();
        nrsp++;
        n_checks += 2;
        if (rsp_rdata !== g.rdata) begin n_fail++; $display("FAIL b2b rdata #%0d: got %h want %h", nrsp, rsp_rdata, g.rdata); end
        if (rsp_err !== g.err) begin n_fail++; $display("FAIL b2b err #%0d: got %b want %b", nrsp, rsp_err, g.err); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (nrsp != 2) begin n_fail++; $display("FAIL b2b count: got %0d responses want 2", nrsp); end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
